// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with shadowed divisor
// reload at period boundaries and a shared phase-align strobe.
module clock_divider_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                    inClk,
    input  logic                    inReset,
    input  logic [NUM_CH-1:0]       inEnable,
    input  logic [NUM_CH*CNT_W-1:0] inDivisor,
    input  logic [NUM_CH-1:0]       inLoad,
    input  logic                    inSync,
    output logic [NUM_CH-1:0]       outClk,
    output logic [NUM_CH-1:0]       outTick,
    output logic [NUM_CH-1:0]       outPending
);

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        logic [CNT_W-1:0] divQ, divD, shadowQ, shadowD, cntQ, cntD, slice;
        logic [CNT_W:0]   halfUp;
        logic             pendQ, pendD, runQ, runD;
        logic             clkQ, tickQ;
        logic             pendIn, wrap, synced, apply;

        assign slice = inDivisor[k*CNT_W +: CNT_W];

        always_comb begin
            shadowD = inLoad[k] ? slice : shadowQ;
            pendIn  = inLoad[k] | pendQ;
            wrap    = runQ && (cntQ == divQ - CNT_W'(1));
            synced  = inSync && inEnable[k];
            // A divisor may only swap in where no partial period can result.
            apply   = pendIn && (wrap || !runQ || !inEnable[k] || synced);
            divD    = apply ? shadowD : divQ;
            pendD   = pendIn && !apply;
            runD    = inEnable[k] && (divD != '0);
            if (!runD || !runQ || synced || wrap) begin
                cntD = '0;
            end else begin
                cntD = cntQ + CNT_W'(1);
            end
            halfUp = ({1'b0, divD} + (CNT_W+1)'(1)) >> 1;
        end

        // Outputs are registered from the next-state count so they line up
        // with the counter value held during the same cycle.
        always_ff @(posedge inClk or posedge inReset) begin
            if (inReset) begin
                divQ    <= CNT_W'(DEFAULT_DIV);
                shadowQ <= CNT_W'(DEFAULT_DIV);
                cntQ    <= '0;
                pendQ   <= 1'b0;
                runQ    <= 1'b0;
                clkQ    <= 1'b0;
                tickQ   <= 1'b0;
            end else begin
                divQ    <= divD;
                shadowQ <= shadowD;
                cntQ    <= cntD;
                pendQ   <= pendD;
                runQ    <= runD;
                clkQ    <= runD && ({1'b0, cntD} < halfUp);
                tickQ   <= runD && !synced && (cntD == divD - CNT_W'(1));
            end
        end

        assign outClk[k]     = clkQ;
        assign outTick[k]    = tickQ;
        assign outPending[k] = pendQ;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed and randomized checks of clock_divider_bank against a
// period-anchor reference model.
module tb_clock_divider_bank;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int DEF = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic [NCH*CW-1:0] div;
    logic [NCH-1:0]   load;
    logic             sync;
    logic [NCH-1:0]   outClk, outTick, outPending;

    clock_divider_bank #(
        .NUM_CH(NCH),
        .CNT_W(CW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .inClk(clk),
        .inReset(rst),
        .inEnable(en),
        .inDivisor(div),
        .inLoad(load),
        .inSync(sync),
        .outClk(outClk),
        .outTick(outTick),
        .outPending(outPending)
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int totalCnt = 0;

    // Model: each channel remembers the cycle number at which its current
    // period train started; phase is elapsed cycles modulo the divisor.
    int mD[NCH], mS[NCH], mP[NCH], mAnchor[NCH];
    bit mRun[NCH];
    int n = 0;
    logic [NCH-1:0] expClk, expTick, expPend;

    function automatic void modelReset();
        for (int k = 0; k < NCH; k++) begin
            mD[k] = DEF; mS[k] = DEF; mP[k] = 0; mRun[k] = 0; mAnchor[k] = 0;
        end
        expClk = '0; expTick = '0; expPend = '0;
    endfunction

    function automatic void modelEdge();
        n++;
        for (int k = 0; k < NCH; k++) begin
            int prevPos, pos;
            bit wrap, synced, wasRun;
            prevPos = mRun[k] ? (n - 1 - mAnchor[k]) % mD[k] : 0;
            wrap    = mRun[k] && (prevPos == mD[k] - 1);
            synced  = sync && en[k];
            wasRun  = mRun[k];
            if (load[k]) begin
                mS[k] = int'(div[k*CW +: CW]);
                mP[k] = 1;
            end
            if (mP[k] != 0 && (wrap || !wasRun || !en[k] || synced)) begin
                mD[k] = mS[k];
                mP[k] = 0;
            end
            mRun[k] = en[k] && (mD[k] != 0);
            if (mRun[k] && (!wasRun || synced || wrap)) mAnchor[k] = n;
            pos = mRun[k] ? (n - mAnchor[k]) % mD[k] : 0;
            expClk[k]  = mRun[k] && (pos < (mD[k] + 1) / 2);
            expTick[k] = mRun[k] && !synced && (pos == mD[k] - 1);
            expPend[k] = (mP[k] != 0);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        chk("outClk", 32'(outClk), 32'(expClk));
        chk("outTick", 32'(outTick), 32'(expTick));
        chk("outPending", 32'(outPending), 32'(expPend));
    endtask

    task automatic ld(input int ch, input int val);
        div[ch*CW +: CW] = CW'(val);
        load[ch] = 1'b1;
        step();
        load[ch] = 1'b0;
    endtask

    logic [9:0] seqClk, seqTick;

    initial begin
        rst = 1'b1; en = '0; div = '0; load = '0; sync = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clk", 32'(outClk), 32'h0);
        chk("reset_tick", 32'(outTick), 32'h0);
        chk("reset_pending", 32'(outPending), 32'h0);
        rst = 1'b0;

        // Default divisor on ch0
        en[0] = 1'b1;
        seqClk = '0; seqTick = '0;
        repeat (4) begin
            step();
            seqClk  = {seqClk[8:0], outClk[0]};
            seqTick = {seqTick[8:0], outTick[0]};
        end
        chk("def_div_clk", 32'(seqClk[3:0]), 32'hA);
        chk("def_div_tick", 32'(seqTick[3:0]), 32'h5);

        // Load 5 into disabled ch1, then run
        ld(1, 5);
        en[1] = 1'b1;
        repeat (10) begin
            step();
            seqClk  = {seqClk[8:0], outClk[1]};
            seqTick = {seqTick[8:0], outTick[1]};
        end
        chk("div5_clk", 32'(seqClk), 32'(10'b1110011100));
        chk("div5_tick", 32'(seqTick), 32'(10'b0000100001));

        // Ch2 at 4, reload 6 mid-period
        ld(2, 4);
        en[2] = 1'b1;
        step();
        step();
        ld(2, 6);
        chk("midload_pending", 32'(outPending[2]), 32'h1);
        repeat (10) begin
            step();
            seqClk  = {seqClk[8:0], outClk[2]};
            seqTick = {seqTick[8:0], outTick[2]};
        end
        chk("reload_clk", 32'(seqClk), 32'(10'b0111000111));
        chk("reload_tick", 32'(seqTick), 32'(10'b1000001000));

        // Ch0=3, ch1=7 free running, then sync
        div[0 +: CW] = CW'(3);
        div[CW +: CW] = CW'(7);
        load = 4'b0011;
        step();
        load = '0;
        repeat (10) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_clk", 32'(outClk[1:0]), 32'h3);
        chk("sync_tick", 32'(outTick[1:0]), 32'h0);
        repeat (22) step();

        // Ch3 stop with 0, then divide-by-one
        en[3] = 1'b1;
        ld(3, 0);
        repeat (8) step();
        chk("stop_clk", 32'(outClk[3]), 32'h0);
        ld(3, 1);
        repeat (3) step();
        chk("div1_clk", 32'(outClk[3]), 32'h1);
        chk("div1_tick", 32'(outTick[3]), 32'h1);

        // Asynchronous reset mid-period with a pending divisor
        ld(2, 9);
        ld(2, 11);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_clk", 32'(outClk), 32'h0);
        chk("async_rst_tick", 32'(outTick), 32'h0);
        chk("async_rst_pending", 32'(outPending), 32'h0);
        modelReset();
        #1 rst = 1'b0;
        repeat (6) step();

        // Randomized traffic
        repeat (400) begin
            for (int k = 0; k < NCH; k++) begin
                en[k]   = ($urandom_range(0, 9) != 0);
                load[k] = ($urandom_range(0, 9) == 0);
                div[k*CW +: CW] = CW'($urandom_range(0, 9));
            end
            sync = ($urandom_range(0, 29) == 0);
            step();
        end
        load = '0; sync = 1'b0;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
